nios_avalon_st_ready_latency_source: RTL and testbench
======================================================

// Module: nios_avalon_st_ready_latency_source
// PURPOSE
//   Source side of an Avalon-ST ready-latency link. Accepts a readyLatency=0 stream
//     (in_valid/in_ready) and drives a sink that declares readyLatency=READY_LATENCY.
//   A beat may only be presented READY_LATENCY cycles after the sink sampled out_ready high.
//   A small FIFO absorbs beats that are in flight while sink ready is low.
//   Sits between the Nios-side stream producers and latency-1+ sinks in the ST adapter path.
// PARAMETERS
//   DATA_WIDTH     42  payload width (data, sop/eop/empty already packed upstream)
//   READY_LATENCY  1   sink ready latency, legal 1..4
//   DEPTH          4   FIFO entries, power of two, >= READY_LATENCY+1
//   ADDR_WIDTH     2   log2(DEPTH)
// PORTS
//   clk         in   1             clock, all logic on rising edge
//   reset_n     in   1             asynchronous, active-low reset
//   in_valid    in   1             upstream beat valid
//   in_data     in   DATA_WIDTH    upstream payload
//   in_ready    out  1             upstream may transfer this cycle (readyLatency 0)
//   out_ready   in   1             sink ready, interpreted with READY_LATENCY
//   out_valid   out  1             beat presented to sink; sink must accept it
//   out_data    out  DATA_WIDTH    payload of presented beat
//   fill_level  out  ADDR_WIDTH+1  entries currently held, 0..DEPTH
// BEHAVIOUR
//   Reset (async assert, sync release): wr_addr=rd_addr=0, count=0, ready_pipe=0,
//     in_ready=1, out_valid=0, fill_level=0. out_data don't-care. FIFO contents discarded.
//   Ready pipeline: ready_pipe[0]<=out_ready; ready_pipe[i]<=ready_pipe[i-1];
//     allowed = ready_pipe[READY_LATENCY-1].
//   Output: out_valid = allowed && (count!=0); out_data = mem[rd_addr] (registered storage,
//     no combinational path from in_* to out_*). out_valid is a completed transfer.
//   Never assert out_valid when allowed=0, even if FIFO is non-empty.
//   Input: in_ready = (count!=DEPTH), decoded from registered count only.
//     write = in_valid && in_ready.
//   Pointers wrap modulo DEPTH. read = out_valid.
//   count: +1 on write only, -1 on read only, unchanged on both or neither.
//   Full: in_ready=0, in_valid ignored; a simultaneous read frees a slot next cycle, not this one.
//   Empty: no bypass. A beat written at edge N is presentable from cycle N+1 if allowed.
//   fill_level = count.
//   Ordering strictly FIFO; no beat dropped or duplicated.
//   in_data is ignored when no write occurs.
//   out_ready toggling only changes allowed after exactly READY_LATENCY edges.
//   Reset mid-operation: all state cleared immediately, including beats held and ready_pipe.
//     First out_valid after release needs out_ready sampled high READY_LATENCY cycles earlier.
// TESTING
//   1 Post-reset, L=1, DEPTH=4 -> in_ready=1, out_valid=0, fill_level=0.
//   2 Fill while out_ready=0: push 0x1..0x4 -> fill_level=4, in_ready=0, out_valid never 1;
//     a 5th in_valid is not accepted.
//   3 From full, out_ready=1 sampled at edge T -> out_valid first at T+1.
//     Data 0x1,0x2,0x3,0x4 on consecutive cycles; in_ready=1 the cycle after first pop.
//   4 Single-cycle out_ready pulse, FIFO holding 3 -> exactly one beat emitted, L cycles later;
//     fill_level 3->2.
//   5 READY_LATENCY=3, DEPTH=4: out_ready 1 at edge T -> first out_valid at T+3.
//     Concurrent push/pop at fill 2 keeps fill_level=2.
//   6 Random in_valid/out_ready (seed 23, 20*DEPTH cycles) with scoreboard -> order preserved,
//     no out_valid without allowed; reset mid-burst -> out_valid=0, fill_level=0 at once.

Source files
------------

// File: rtl/nios_avalon_st_ready_latency_source_if.sv
// Avalon-ST handshake bundle for the ready-latency source. The upstream stream is
// readyLatency 0. The downstream stream is interpreted with the sink's ready latency.
interface nios_avalon_st_ready_latency_source_if #(
  parameter int DATA_WIDTH = 42,
  parameter int ADDR_WIDTH = 2
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH:0]   fill_level;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, fill_level
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, fill_level
  );
endinterface

// File: rtl/nios_avalon_st_ready_latency_source.sv
// Bridges a readyLatency=0 stream onto a sink with READY_LATENCY >= 1.
// A small FIFO holds beats that are in flight while the sink's ready is low.
module nios_avalon_st_ready_latency_source #(
  parameter int DATA_WIDTH    = 42,
  parameter int READY_LATENCY = 1,
  parameter int DEPTH         = 4,
  parameter int ADDR_WIDTH    = 2
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  nios_avalon_st_ready_latency_source_if.slave  st
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [ADDR_WIDTH-1:0]    wr_addr;
  logic [ADDR_WIDTH-1:0]    rd_addr;
  logic [ADDR_WIDTH:0]      count;
  logic [READY_LATENCY-1:0] ready_pipe;
  logic [READY_LATENCY:0]   pipe_next;
  logic                     allowed;
  logic                     do_write;
  logic                     do_read;

  // The extra bit keeps the shift legal when READY_LATENCY is 1.
  assign pipe_next = {ready_pipe, st.out_ready};
  assign allowed   = ready_pipe[READY_LATENCY-1];

  // Both handshakes are decoded from registered state only.
  // This leaves no combinational path from in_* to out_*.
  assign st.in_ready   = (count != FULL_COUNT);
  assign st.out_valid  = allowed && (count != '0);
  assign st.out_data   = mem[rd_addr];
  assign st.fill_level = count;

  assign do_write = st.in_valid && st.in_ready;
  assign do_read  = st.out_valid;

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_addr] <= st.in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr    <= '0;
      rd_addr    <= '0;
      count      <= '0;
      ready_pipe <= '0;
    end else begin
      ready_pipe <= pipe_next[READY_LATENCY-1:0];
      if (do_write) begin
        wr_addr <= wr_addr + 1'b1;
      end
      if (do_read) begin
        rd_addr <= rd_addr + 1'b1;
      end
      case ({do_write, do_read})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_avalon_st_ready_latency_source.sv
// Directed and seeded-random checks of the ready-latency source.
// DUTs are instantiated with READY_LATENCY 1 and 3.
module tb_nios_avalon_st_ready_latency_source;

  localparam int DW = 42;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  nios_avalon_st_ready_latency_source_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(2)) bus1 ();
  nios_avalon_st_ready_latency_source_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(2)) bus3 ();

  nios_avalon_st_ready_latency_source #(
    .DATA_WIDTH(DW), .READY_LATENCY(1), .DEPTH(4), .ADDR_WIDTH(2)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .st(bus1)
  );

  nios_avalon_st_ready_latency_source #(
    .DATA_WIDTH(DW), .READY_LATENCY(3), .DEPTH(4), .ADDR_WIDTH(2)
  ) dut3 (
    .clk(clk), .reset_n(reset_n), .st(bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic push1(input logic [DW-1:0] d, input string tag);
    bus1.in_valid = 1'b1;
    bus1.in_data  = d;
    tick();
    bus1.in_valid = 1'b0;
    check(tag, 64'(bus1.out_valid), 64'd0);
  endtask

  logic [DW-1:0] q[$];
  logic          prev_or;
  logic          exp_valid;
  logic          iv;
  logic          wr;
  logic [DW-1:0] d;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    void'($urandom(23));
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
    bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.out_ready = 1'b0;
    do_reset();

    // 1: reset state
    check("rst_in_ready",  64'(bus1.in_ready),   64'd1);
    check("rst_out_valid", 64'(bus1.out_valid),  64'd0);
    check("rst_fill",      64'(bus1.fill_level), 64'd0);
    check("rst3_fill",     64'(bus3.fill_level), 64'd0);

    // 2: fill to capacity while sink is not ready
    for (int i = 1; i <= 4; i++) push1(DW'(i), "fill_no_valid");
    check("full_fill",     64'(bus1.fill_level), 64'd4);
    check("full_in_ready", 64'(bus1.in_ready),   64'd0);
    push1(DW'(5), "fifth_no_valid");
    check("fifth_rejected", 64'(bus1.fill_level), 64'd4);

    // 3: drain from full with latency 1
    bus1.out_ready = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("drain_valid",    64'(bus1.out_valid),  64'd1);
      check("drain_data",     64'(bus1.out_data),   64'(k + 1));
      check("drain_fill",     64'(bus1.fill_level), 64'(4 - k));
      check("drain_in_ready", 64'(bus1.in_ready),   (k == 0) ? 64'd0 : 64'd1);
      tick();
    end
    check("drained_valid", 64'(bus1.out_valid),  64'd0);
    check("drained_fill",  64'(bus1.fill_level), 64'd0);
    bus1.out_ready = 1'b0;
    tick();

    // 4: a single-cycle ready pulse releases exactly one beat
    push1(DW'('hA), "p4_push");
    push1(DW'('hB), "p4_push");
    push1(DW'('hC), "p4_push");
    check("p4_fill3", 64'(bus1.fill_level), 64'd3);
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
    check("p4_valid", 64'(bus1.out_valid),  64'd1);
    check("p4_data",  64'(bus1.out_data),   64'hA);
    check("p4_fillA", 64'(bus1.fill_level), 64'd3);
    tick();
    check("p4_one_only", 64'(bus1.out_valid),  64'd0);
    check("p4_fill2",    64'(bus1.fill_level), 64'd2);
    tick();
    check("p4_still_off", 64'(bus1.out_valid), 64'd0);

    // 5: latency 3, then a simultaneous push and pop at fill 2
    bus3.in_valid = 1'b1; bus3.in_data = DW'('h21); tick();
    bus3.in_data = DW'('h22); tick();
    bus3.in_valid = 1'b0;
    check("l3_fill2", 64'(bus3.fill_level), 64'd2);
    bus3.out_ready = 1'b1;
    tick();
    check("l3_t1_off", 64'(bus3.out_valid), 64'd0);
    tick();
    check("l3_t2_off", 64'(bus3.out_valid), 64'd0);
    tick();
    check("l3_t3_valid", 64'(bus3.out_valid), 64'd1);
    check("l3_t3_data",  64'(bus3.out_data),  64'h21);
    bus3.in_valid = 1'b1; bus3.in_data = DW'('h23);
    tick();
    bus3.in_valid = 1'b0; bus3.out_ready = 1'b0;
    check("l3_pushpop_fill", 64'(bus3.fill_level), 64'd2);
    check("l3_data22",       64'(bus3.out_data),   64'h22);
    tick();
    check("l3_data23", 64'(bus3.out_data),   64'h23);
    check("l3_fill1",  64'(bus3.fill_level), 64'd1);
    tick();
    check("l3_empty", 64'(bus3.fill_level), 64'd0);

    // 6: seeded random traffic against a queue model, latency 1
    do_reset();
    prev_or = 1'b0;
    q.delete();
    for (int c = 0; c < 80; c++) begin
      exp_valid = prev_or && (q.size() != 0);
      check("rnd_valid",    64'(bus1.out_valid),  64'(exp_valid));
      check("rnd_fill",     64'(bus1.fill_level), 64'(q.size()));
      check("rnd_in_ready", 64'(bus1.in_ready),   64'(q.size() != 4));
      if (exp_valid) check("rnd_data", 64'(bus1.out_data), 64'(q[0]));
      iv = 1'($urandom_range(1, 0));
      d  = DW'({$urandom(), $urandom()});
      bus1.in_valid  = iv;
      bus1.in_data   = d;
      bus1.out_ready = 1'($urandom_range(1, 0));
      wr = iv && (q.size() != 4);
      tick();
      if (exp_valid) void'(q.pop_front());
      if (wr) q.push_back(d);
      prev_or = bus1.out_ready;
    end

    // Reset in the middle of a burst clears state at once
    bus1.in_valid = 1'b1; bus1.out_ready = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("midrst_valid",    64'(bus1.out_valid),  64'd0);
    check("midrst_fill",     64'(bus1.fill_level), 64'd0);
    check("midrst_in_ready", 64'(bus1.in_ready),   64'd1);
    bus1.in_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    push1(DW'('h77), "post_rst_hold");
    check("post_rst_fill", 64'(bus1.fill_level), 64'd1);
    bus1.out_ready = 1'b1;
    tick();
    check("post_rst_valid", 64'(bus1.out_valid), 64'd1);
    check("post_rst_data",  64'(bus1.out_data),  64'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
